hall_speed_meter: RTL and testbench
===================================

// Module: hall_speed_meter
// PURPOSE
//  Consumes one motor's Hall feedback line (S1A/S2A, m1_feedback/m2_feedback from the H-bridge connector).
//  Synchronises and glitch-filters it, then measures speed two ways:
//    - rising edges counted per fixed window
//    - clock cycles between consecutive rising edges
//  One instance per motor; results go to AXI GPIO inputs / the speed control loop.
// PARAMETERS
//  WINDOW_CYCLES  10_000_000  count window length in clk cycles (100 ms at 100 MHz); >= 2
//  FILTER_CYCLES  16          consecutive stable cycles needed to accept a level change; >= 1
//  COUNT_W        16          edge_count width
//  PERIOD_W       24          period width
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high reset
//  enable        in   1         measurement enable; low = soft clear (see below)
//  feedback      in   1         raw Hall signal, asynchronous to clk
//  edge_count    out  COUNT_W   rising edges in last completed window
//  count_valid   out  1         1-cycle pulse when edge_count updates
//  period        out  PERIOD_W  cycles between last two filtered rising edges
//  period_valid  out  1         1-cycle pulse when period updates
//  stalled       out  1         high while no rising edge for 2^PERIOD_W-1 cycles
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, filtered level, filter/window/period counters, accumulator, armed flag = 0.
//  Sync: 2-FF synchroniser on feedback.
//  Filter: filtered level changes only after the sync output differs from it for FILTER_CYCLES consecutive cycles.
//    - Any return to the current level clears the filter count.
//  rise: 1-cycle internal strobe, cycle after filtered goes 0->1.
//    - Latency from a stable raw edge to rise = 2 + FILTER_CYCLES + 1 cycles.
//  Window: wcnt runs 0..WINDOW_CYCLES-1 then wraps. At terminal cycle:
//    - edge_count <= acc + rise (saturating)
//    - acc <= 0
//    - count_valid = 1 next cycle
//    - Otherwise acc += rise, saturating at 2^COUNT_W-1.
//    - A rise on the terminal cycle counts in the closing window, never twice.
//  Period: pcnt increments every cycle, saturating at 2^PERIOD_W-1.
//    - On rise: if armed and pcnt not saturated, period <= pcnt and period_valid pulses.
//    - On every rise: pcnt <= 1, armed <= 1.
//    - So rises at cycles t0 and t1 give period = t1 - t0.
//  Stall: when pcnt saturates, stalled <= 1 and armed <= 0.
//    - Next rise clears stalled, emits no period, and re-arms.
//  Enable low, each cycle:
//    - wcnt, acc, pcnt, armed, stalled = 0; valid pulses = 0.
//    - edge_count/period hold their values.
//    - Sync and filter keep running, so a level held across enable high gives no spurious rise.
//  Reset mid-operation: everything returns to reset state next cycle; no valid pulse that cycle.
//  Valid pulses are never held or queued; the consumer samples on the pulse.
// TESTING
//  1 Reset with feedback toggling -> all outputs 0 during reset and on the first cycle after.
//  2 FILTER_CYCLES=16: 15-cycle high glitch -> no rise, acc 0; 16-cycle high -> exactly 1 rise.
//  3 WINDOW_CYCLES=10000, square wave period 1000 -> edge_count=10 every count_valid;
//    period=1000 from the 2nd rise on.
//  4 PERIOD_W=12, no edges -> stalled=1 after 4095 cycles; next rise: no period_valid, stalled=0;
//    2nd rise 500 cycles later -> period=500.
//  5 Rise aligned to window terminal cycle -> counted once in the closing window; next window starts at 0.
//  6 Drop enable mid-window with acc=7 -> no count_valid, edge_count keeps old value;
//    re-enable -> full fresh window, first rise gives no period.

Source files
------------

// File: rtl/hall_speed_meter.sv
// Hall feedback speed meter: 2-FF synchroniser, stability filter, then edges-per-window
// and cycles-between-edges measurements with a stall flag.
module hall_speed_meter #(
   parameter int unsigned WINDOW_CYCLES = 10_000_000,
   parameter int unsigned FILTER_CYCLES = 16,
   parameter int unsigned COUNT_W       = 16,
   parameter int unsigned PERIOD_W      = 24
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                enable_i,
   input  logic                feedback_i,
   output logic [COUNT_W-1:0]  edge_count_o,
   output logic                count_valid_o,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   output logic                stalled_o
);

   localparam int unsigned WCNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned FCNT_W = $clog2(FILTER_CYCLES + 1);

   localparam logic [WCNT_W-1:0]   W_LAST  = WCNT_W'(WINDOW_CYCLES - 1);
   localparam logic [FCNT_W-1:0]   F_LAST  = FCNT_W'(FILTER_CYCLES - 1);
   localparam logic [COUNT_W-1:0]  CNT_MAX = '1;
   localparam logic [PERIOD_W-1:0] PER_MAX = '1;

   // input conditioning
   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                filt_q, filt_d;
   logic                filt_prev_q, filt_prev_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                rise_q, rise_d;

   // measurement state
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [COUNT_W-1:0]  acc_q, acc_d;
   logic [COUNT_W-1:0]  acc_inc;
   logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
   logic                armed_q, armed_d;

   // registered outputs
   logic [COUNT_W-1:0]  edge_count_q, edge_count_d;
   logic                count_valid_q, count_valid_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                period_valid_q, period_valid_d;
   logic                stalled_q, stalled_d;

   // Synchroniser and filter run regardless of enable so a level held across
   // re-enable never looks like a fresh edge.
   always_comb begin
      sync1_d     = feedback_i;
      sync2_d     = sync1_q;
      filt_d      = filt_q;
      fcnt_d      = '0;
      filt_prev_d = filt_q;
      rise_d      = filt_q & ~filt_prev_q;

      if (sync2_q != filt_q) begin
         if (fcnt_q == F_LAST) begin
            filt_d = sync2_q;
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end
   end

   // Window counter, period counter and stall tracking.
   always_comb begin
      wcnt_d         = wcnt_q;
      acc_d          = acc_q;
      pcnt_d         = pcnt_q;
      armed_d        = armed_q;
      edge_count_d   = edge_count_q;
      count_valid_d  = 1'b0;
      period_d       = period_q;
      period_valid_d = 1'b0;
      stalled_d      = stalled_q;

      acc_inc = (rise_q && (acc_q != CNT_MAX)) ? acc_q + COUNT_W'(1) : acc_q;

      if (!enable_i) begin
         wcnt_d    = '0;
         acc_d     = '0;
         pcnt_d    = '0;
         armed_d   = 1'b0;
         stalled_d = 1'b0;
      end else begin
         // A rise on the terminal cycle lands in the closing window only.
         if (wcnt_q == W_LAST) begin
            wcnt_d        = '0;
            edge_count_d  = acc_inc;
            acc_d         = '0;
            count_valid_d = 1'b1;
         end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            acc_d  = acc_inc;
         end

         if (rise_q) begin
            if (armed_q && (pcnt_q != PER_MAX)) begin
               period_d       = pcnt_q;
               period_valid_d = 1'b1;
            end
            pcnt_d    = PERIOD_W'(1);
            armed_d   = 1'b1;
            stalled_d = 1'b0;
         end else if (pcnt_q == PER_MAX) begin
            stalled_d = 1'b1;
            armed_d   = 1'b0;
         end else begin
            pcnt_d = pcnt_q + PERIOD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         filt_q         <= 1'b0;
         filt_prev_q    <= 1'b0;
         fcnt_q         <= '0;
         rise_q         <= 1'b0;
         wcnt_q         <= '0;
         acc_q          <= '0;
         pcnt_q         <= '0;
         armed_q        <= 1'b0;
         edge_count_q   <= '0;
         count_valid_q  <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         stalled_q      <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         filt_q         <= filt_d;
         filt_prev_q    <= filt_prev_d;
         fcnt_q         <= fcnt_d;
         rise_q         <= rise_d;
         wcnt_q         <= wcnt_d;
         acc_q          <= acc_d;
         pcnt_q         <= pcnt_d;
         armed_q        <= armed_d;
         edge_count_q   <= edge_count_d;
         count_valid_q  <= count_valid_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         stalled_q      <= stalled_d;
      end
   end

   assign edge_count_o   = edge_count_q;
   assign count_valid_o  = count_valid_q;
   assign period_o       = period_q;
   assign period_valid_o = period_valid_q;
   assign stalled_o      = stalled_q;

endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: scenario tasks plus a timestamp-based reference model.
module tb_hall_speed_meter;

   localparam int unsigned W   = 10000;
   localparam int unsigned F   = 16;
   localparam int unsigned CW  = 16;
   localparam int unsigned PW  = 12;
   localparam int          PMAX = (1 << PW) - 1;
   localparam int          CMAX = (1 << CW) - 1;
   localparam int          LAT  = F + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          feedback = 1'b0;
   logic [CW-1:0] edge_count;
   logic          count_valid;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          stalled;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   hall_speed_meter #(
      .WINDOW_CYCLES(W),
      .FILTER_CYCLES(F),
      .COUNT_W      (CW),
      .PERIOD_W     (PW)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .enable_i      (enable),
      .feedback_i    (feedback),
      .edge_count_o  (edge_count),
      .count_valid_o (count_valid),
      .period_o      (period),
      .period_valid_o(period_valid),
      .stalled_o     (stalled)
   );

   // Reference model: timestamps, a sample history and modulo window arithmetic.
   int  m_t = 0;
   int  m_rise_at = -1;
   bit  fbq[$];
   bit  m_filt = 0;
   int  m_run = 0;
   int  m_idx = 0;
   int  m_ref = 0;
   int  m_acc = 0;
   bit  m_armed = 0;
   int  m_cnt = 0;
   int  m_per = 0;
   bit  m_cv = 0;
   bit  m_pv = 0;
   bit  m_stalled = 0;

   always @(posedge clk) begin : model_blk
      bit sync;
      bit rise;
      int age;
      rise = (m_t == m_rise_at);
      if (reset) begin
         fbq.delete();
         m_rise_at = -1;
         m_filt = 0; m_run = 0;
         m_idx = 0; m_ref = 0; m_acc = 0; m_armed = 0;
         m_cnt = 0; m_per = 0; m_cv = 0; m_pv = 0; m_stalled = 0;
      end else begin
         sync = (fbq.size() >= 2) ? fbq[fbq.size()-2] : 1'b0;
         fbq.push_back(feedback);
         if (fbq.size() > 3) void'(fbq.pop_front());
         if (sync != m_filt) begin
            m_run++;
            if (m_run == int'(F)) begin
               m_filt = sync;
               m_run = 0;
               if (sync) m_rise_at = m_t + 2;
            end
         end else begin
            m_run = 0;
         end

         m_cv = 0;
         m_pv = 0;
         if (!enable) begin
            m_idx = 0; m_ref = 0; m_acc = 0; m_armed = 0; m_stalled = 0;
         end else begin
            age = m_idx - m_ref;
            if (age > PMAX) age = PMAX;
            if ((m_idx % int'(W)) == int'(W) - 1) begin
               m_cnt = m_acc + int'(rise);
               if (m_cnt > CMAX) m_cnt = CMAX;
               m_acc = 0;
               m_cv = 1;
            end else begin
               m_acc = m_acc + int'(rise);
               if (m_acc > CMAX) m_acc = CMAX;
            end
            if (rise) begin
               if (m_armed && age != PMAX) begin
                  m_per = age;
                  m_pv = 1;
               end
               m_ref = m_idx;
               m_armed = 1;
               m_stalled = 0;
            end else if (age == PMAX) begin
               m_stalled = 1;
               m_armed = 0;
            end
            m_idx++;
         end
      end
      m_t++;
   end

   // Counts cycles where any DUT output disagrees with the model.
   int mis_n = 0;
   bit mon_en = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (edge_count !== CW'(m_cnt) || count_valid !== m_cv || period !== PW'(m_per) ||
             period_valid !== m_pv || stalled !== m_stalled)
            mis_n++;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      feedback = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         feedback = 1'($urandom_range(0, 1));
         @(negedge clk);
         mon_en = 1'b1;
         tests_run++;
         if ({edge_count, count_valid, period, period_valid, stalled} !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: cycle %0d outputs %h, expected 0", i,
                     {edge_count, count_valid, period, period_valid, stalled});
         end
      end
      reset = 1'b0;
      feedback = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if ({edge_count, count_valid, period, period_valid, stalled} !== '0) begin
         tests_failed++;
         $display("FAIL reset_release: outputs %h, expected 0",
                  {edge_count, count_valid, period, period_valid, stalled});
      end
   endtask

   task automatic test_filter();
      int cv_n = 0, pv_n = 0, got = -1, glen = 1, snap;
      do_reset();
      snap = mis_n;
      for (int i = 0; i < int'(W); i++) begin
         if (i >= 1000 && i < 7000 && (i % 200) == 0) glen = $urandom_range(1, F - 1);
         if (i >= 100 && i < 100 + int'(F) - 1)      feedback = 1'b1;
         else if (i >= 400 && i < 400 + int'(F))     feedback = 1'b1;
         else if (i >= 1000 && i < 7000)             feedback = 1'((i % 200) < glen);
         else                                        feedback = 1'b0;
         @(negedge clk);
         if (count_valid === 1'b1) begin cv_n++; got = int'(edge_count); end
         if (period_valid === 1'b1) pv_n++;
      end
      tests_run++;
      if (got != 1) begin
         tests_failed++;
         $display("FAIL filter_count: edge_count %0d, expected 1", got);
      end
      tests_run++;
      if (cv_n != 1) begin
         tests_failed++;
         $display("FAIL filter_cv: %0d count_valid pulses, expected 1", cv_n);
      end
      tests_run++;
      if (pv_n != 0) begin
         tests_failed++;
         $display("FAIL filter_pv: %0d period_valid pulses, expected 0", pv_n);
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL filter_model: %0d differing cycles, expected 0", mis_n - snap);
      end
   endtask

   task automatic test_window_period();
      int cv_n = 0, pv_n = 0, snap;
      do_reset();
      snap = mis_n;
      for (int i = 0; i < 20100; i++) begin
         feedback = 1'((i % 1000) < 500);
         @(negedge clk);
         if (count_valid === 1'b1) begin
            cv_n++;
            tests_run++;
            if (edge_count !== CW'(10)) begin
               tests_failed++;
               $display("FAIL window_count: edge_count %0d, expected 10", edge_count);
            end
         end
         if (period_valid === 1'b1) begin
            pv_n++;
            tests_run++;
            if (period !== PW'(1000)) begin
               tests_failed++;
               $display("FAIL square_period: period %0d, expected 1000", period);
            end
         end
      end
      tests_run++;
      if (cv_n != 2 || pv_n != 20) begin
         tests_failed++;
         $display("FAIL square_pulses: cv %0d pv %0d, expected cv 2 pv 20", cv_n, pv_n);
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL square_model: %0d differing cycles, expected 0", mis_n - snap);
      end
   endtask

   task automatic test_stall();
      int first = -1, pv_n = 0, last = -1, snap;
      do_reset();
      snap = mis_n;
      for (int i = 0; i < 4200 && first < 0; i++) begin
         feedback = 1'b0;
         @(negedge clk);
         if (stalled === 1'b1) first = i;
      end
      tests_run++;
      if (first != PMAX) begin
         tests_failed++;
         $display("FAIL stall_time: stalled at cycle %0d, expected %0d", first, PMAX);
      end
      for (int i = 0; i < 700; i++) begin
         feedback = 1'((i < 100) || (i >= 500 && i < 600));
         @(negedge clk);
         if (period_valid === 1'b1) begin pv_n++; last = int'(period); end
         if (i == LAT - 1) begin
            tests_run++;
            if (stalled !== 1'b1) begin
               tests_failed++;
               $display("FAIL stall_hold: stalled %b, expected 1", stalled);
            end
         end
         if (i == LAT) begin
            tests_run++;
            if (stalled !== 1'b0) begin
               tests_failed++;
               $display("FAIL stall_clear: stalled %b, expected 0", stalled);
            end
         end
      end
      tests_run++;
      if (pv_n != 1 || last != 500) begin
         tests_failed++;
         $display("FAIL stall_period: %0d pulses last %0d, expected 1 pulse of 500", pv_n, last);
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL stall_model: %0d differing cycles, expected 0", mis_n - snap);
      end
   endtask

   task automatic test_terminal();
      int cv_n = 0, snap;
      int cv_val[2];
      int cv_at[2];
      do_reset();
      snap = mis_n;
      for (int i = 0; i < 2 * int'(W); i++) begin
         feedback = 1'((i >= int'(W) - 1 - LAT && i < int'(W) + 100) || (i >= 15000 && i < 15100));
         @(negedge clk);
         if (count_valid === 1'b1) begin
            if (cv_n < 2) begin cv_val[cv_n] = int'(edge_count); cv_at[cv_n] = i; end
            cv_n++;
         end
      end
      tests_run++;
      if (cv_n != 2) begin
         tests_failed++;
         $display("FAIL term_pulses: %0d count_valid pulses, expected 2", cv_n);
      end else begin
         tests_run++;
         if (cv_val[0] != 1 || cv_at[0] != int'(W) - 1) begin
            tests_failed++;
            $display("FAIL term_close: count %0d at %0d, expected 1 at %0d", cv_val[0], cv_at[0], W - 1);
         end
         tests_run++;
         if (cv_val[1] != 1 || cv_at[1] != 2 * int'(W) - 1) begin
            tests_failed++;
            $display("FAIL term_next: count %0d at %0d, expected 1 at %0d", cv_val[1], cv_at[1], 2 * W - 1);
         end
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL term_model: %0d differing cycles, expected 0", mis_n - snap);
      end
   endtask

   task automatic test_enable();
      int cv_at = -1, got = -1, pv_n = 0, last = -1, snap;
      snap = mis_n;
      for (int i = 0; i < 3000; i++) begin
         feedback = 1'((i % 200) < 100 && i < 1400);
         @(negedge clk);
      end
      tests_run++;
      if (edge_count !== CW'(1) || period !== PW'(200)) begin
         tests_failed++;
         $display("FAIL en_before: edge_count %0d period %0d, expected 1 and 200", edge_count, period);
      end
      enable = 1'b0;
      for (int i = 0; i < 300; i++) begin
         feedback = 1'(i >= 50);
         @(negedge clk);
         tests_run++;
         if (count_valid !== 1'b0 || period_valid !== 1'b0 || stalled !== 1'b0 ||
             edge_count !== CW'(1) || period !== PW'(200)) begin
            tests_failed++;
            $display("FAIL en_low: cv %b pv %b st %b cnt %0d per %0d, expected 0 0 0 1 200",
                     count_valid, period_valid, stalled, edge_count, period);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < int'(W) + 100 && cv_at < 0; i++) begin
         feedback = 1'((i < 100) || (i >= 400 && i < 550) || (i >= 700 && i < 850) ||
                       (i >= 1000 && i < 1150));
         @(negedge clk);
         if (period_valid === 1'b1) begin pv_n++; last = int'(period); end
         if (count_valid === 1'b1) begin cv_at = i; got = int'(edge_count); end
      end
      tests_run++;
      if (cv_at != int'(W) - 1 || got != 3) begin
         tests_failed++;
         $display("FAIL en_window: count %0d at %0d, expected 3 at %0d", got, cv_at, W - 1);
      end
      tests_run++;
      if (pv_n != 2 || last != 300) begin
         tests_failed++;
         $display("FAIL en_period: %0d pulses last %0d, expected 2 pulses of 300", pv_n, last);
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL en_model: %0d differing cycles, expected 0", mis_n - snap);
      end
   endtask

   task automatic test_back_to_back();
      int seg = 0, en_off = 0, snap;
      logic lvl = 1'b0;
      snap = mis_n;
      for (int i = 0; i < 6000; i++) begin
         if (seg == 0) begin lvl = ~lvl; seg = $urandom_range(3, 300); end
         seg--;
         if (en_off > 0) en_off--;
         else if ($urandom_range(0, 999) == 0) en_off = $urandom_range(5, 200);
         enable = (en_off == 0);
         feedback = lvl;
         @(negedge clk);
      end
      tests_run++;
      if (mis_n != snap) begin
         tests_failed++;
         $display("FAIL random_model: %0d differing cycles, expected 0", mis_n - snap);
      end
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({edge_count, count_valid, period, period_valid, stalled} !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset: outputs %h, expected 0",
                  {edge_count, count_valid, period, period_valid, stalled});
      end
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_filter();
      test_window_period();
      test_stall();
      test_terminal();
      test_enable();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
